// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one byte-addressable memory between instruction fetch and load/store.
// Data has priority; a saturating starvation counter lets fetch win the tie after STARVE_LIMIT losses.
module mem_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [AWIDTH-1:0] if_req_addr_i,
    output logic              if_rsp_valid_o,
    input  logic              if_rsp_ready_i,
    output logic [DWIDTH-1:0] if_rsp_data_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [AWIDTH-1:0] d_req_addr_i,
    input  logic              d_req_we_i,
    input  logic [2:0]        d_req_size_i,
    input  logic [DWIDTH-1:0] d_req_wdata_i,
    output logic              d_rsp_valid_o,
    input  logic              d_rsp_ready_i,
    output logic [DWIDTH-1:0] d_rsp_data_o,
    output logic              d_rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [2:0]        mem_size_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic              r_if_rsp_valid;
    logic [DWIDTH-1:0] r_if_rsp_data;
    logic              r_d_rsp_valid;
    logic [DWIDTH-1:0] r_d_rsp_data;
    logic              r_d_rsp_err;
    logic [CW-1:0]     r_starve_cnt;

    logic w_if_elig;
    logic w_d_elig;
    logic w_if_grant;
    logic w_d_grant;
    logic w_d_misaligned;

    // Undefined sizes fall into the word rule.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic result;
        case (size)
            3'd0, 3'd4: result = 1'b0;
            3'd1, 3'd5: result = addr_lo[0];
            default:    result = (addr_lo != 2'b00);
        endcase
        return result;
    endfunction

    assign w_if_elig      = if_req_valid_i && (!r_if_rsp_valid || if_rsp_ready_i);
    assign w_d_elig       = d_req_valid_i && (!r_d_rsp_valid || d_rsp_ready_i);
    assign w_if_grant     = !rst && w_if_elig && (!w_d_elig || (r_starve_cnt == LIMIT));
    assign w_d_grant      = !rst && w_d_elig && !w_if_grant;
    assign w_d_misaligned = misaligned(d_req_size_i, d_req_addr_i[1:0]);

    assign if_req_ready_o = w_if_grant;
    assign d_req_ready_o  = w_d_grant;
    assign if_rsp_valid_o = r_if_rsp_valid;
    assign if_rsp_data_o  = r_if_rsp_data;
    assign d_rsp_valid_o  = r_d_rsp_valid;
    assign d_rsp_data_o   = r_d_rsp_data;
    assign d_rsp_err_o    = r_d_rsp_err;

    // Memory drive for the granted port; everything idles at zero otherwise.
    always_comb begin
        mem_addr_o     = {AWIDTH{1'b0}};
        mem_data_o     = {DWIDTH{1'b0}};
        mem_size_o     = 3'd0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (w_if_grant) begin
            mem_addr_o    = {if_req_addr_i[AWIDTH-1:2], 2'b00};
            mem_size_o    = 3'b010;
            mem_read_en_o = 1'b1;
        end else if (w_d_grant) begin
            mem_addr_o     = d_req_addr_i;
            mem_data_o     = d_req_wdata_i;
            mem_size_o     = d_req_size_i;
            mem_read_en_o  = !d_req_we_i && !w_d_misaligned;
            mem_write_en_o = d_req_we_i && !w_d_misaligned;
        end else begin
            mem_addr_o = {AWIDTH{1'b0}};
        end
    end

    // Fetch response buffer: a new capture wins over a same-edge drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= {DWIDTH{1'b0}};
        end else if (w_if_grant) begin
            r_if_rsp_valid <= 1'b1;
            r_if_rsp_data  <= mem_data_i;
        end else if (r_if_rsp_valid && if_rsp_ready_i) begin
            r_if_rsp_valid <= 1'b0;
        end else begin
            r_if_rsp_valid <= r_if_rsp_valid;
        end
    end

    // Data response buffer: stores and rejected accesses return zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= {DWIDTH{1'b0}};
            r_d_rsp_err   <= 1'b0;
        end else if (w_d_grant) begin
            r_d_rsp_valid <= 1'b1;
            r_d_rsp_data  <= (d_req_we_i || w_d_misaligned) ? {DWIDTH{1'b0}} : mem_data_i;
            r_d_rsp_err   <= w_d_misaligned;
        end else if (r_d_rsp_valid && d_rsp_ready_i) begin
            r_d_rsp_valid <= 1'b0;
        end else begin
            r_d_rsp_valid <= r_d_rsp_valid;
        end
    end

    // Consecutive fetch losses; a fetch held off by its own full buffer neither counts nor clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= {CW{1'b0}};
        end else if (!if_req_valid_i || w_if_grant) begin
            r_starve_cnt <= {CW{1'b0}};
        end else if (w_if_elig && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table vectors, directed corner sequences and random traffic
// against a transaction-level reference model with its own shadow memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifv = 1'b0, if_rr = 1'b1, dv = 1'b0, d_rr = 1'b1, dwe = 1'b0;
    logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic [2:0]  d_size = 3'd0;
    logic        if_rdy, if_rv, d_rdy, d_rv, d_err, m_ren, m_wen;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;

    logic [31:0] env_mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_dat = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          mf_full, md_full, md_err;
    logic [31:0] mf_data, md_data;
    int          m_starve;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(ifv), .if_req_ready_o(if_rdy), .if_req_addr_i(if_addr),
        .if_rsp_valid_o(if_rv), .if_rsp_ready_i(if_rr), .if_rsp_data_o(if_rdata),
        .d_req_valid_i(dv), .d_req_ready_o(d_rdy), .d_req_addr_i(d_addr),
        .d_req_we_i(dwe), .d_req_size_i(d_size), .d_req_wdata_i(d_wdata),
        .d_rsp_valid_o(d_rv), .d_rsp_ready_i(d_rr), .d_rsp_data_o(d_rdata), .d_rsp_err_o(d_err),
        .mem_addr_o(m_addr), .mem_data_o(m_wdata), .mem_size_o(m_size),
        .mem_read_en_o(m_ren), .mem_write_en_o(m_wen), .mem_data_i(m_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] sz, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * off));
        h = 16'(w >> (16 * off[1]));
        case (sz)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] wd,
                                             input logic [2:0] sz, input logic [1:0] off);
        logic [31:0] m;
        case (sz)
            3'd0, 3'd4: m = 32'hFF << (8 * off);
            3'd1, 3'd5: m = 32'hFFFF << (16 * off[1]);
            default:    m = 32'hFFFF_FFFF;
        endcase
        return (w & ~m) | ((wd << (8 * off)) & m);
    endfunction

    function automatic bit misal(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'd0 || sz == 3'd4) return 1'b0;
        if (sz == 3'd1 || sz == 3'd5) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    // Environment memory: combinational read, posedge write
    assign m_rdata = m_ren ? ld_ext(env_mem[m_addr[7:2]], m_size, m_addr[1:0]) : 32'h0;

    always @(posedge clk) begin
        if (pre_en) env_mem[pre_idx] <= pre_dat;
        else if (m_wen) env_mem[m_addr[7:2]] <= st_merge(env_mem[m_addr[7:2]], m_wdata, m_size, m_addr[1:0]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mf_full = 0; md_full = 0; md_err = 0;
        mf_data = 32'h0; md_data = 32'h0; m_starve = 0;
    endtask

    // One clock: check DUT against the model for the current inputs, then advance both.
    task automatic step();
        bit fe, de, fw, dw, mis;
        #1;
        fe  = ifv && (!mf_full || if_rr);
        de  = dv && (!md_full || d_rr);
        fw  = fe && (!de || m_starve == 4);
        dw  = de && !fw;
        mis = misal(d_size, d_addr);
        chk("if_rsp_valid", 32'(if_rv), 32'(mf_full));
        chk("if_rsp_data", if_rdata, mf_data);
        chk("d_rsp_valid", 32'(d_rv), 32'(md_full));
        chk("d_rsp_data", d_rdata, md_data);
        chk("d_rsp_err", 32'(d_err), 32'(md_err));
        chk("if_req_ready", 32'(if_rdy), 32'(fw));
        chk("d_req_ready", 32'(d_rdy), 32'(dw));
        chk("mem_read_en", 32'(m_ren), 32'(fw || (dw && !dwe && !mis)));
        chk("mem_write_en", 32'(m_wen), 32'(dw && dwe && !mis));
        if (fw) begin
            chk("mem_addr_f", m_addr, if_addr & ~32'h3);
            chk("mem_size_f", 32'(m_size), 32'd2);
        end else if (dw) begin
            chk("mem_addr_d", m_addr, d_addr);
            chk("mem_size_d", 32'(m_size), 32'(d_size));
            chk("mem_data_d", m_wdata, d_wdata);
        end else begin
            chk("mem_addr_idle", m_addr, 32'h0);
        end
        @(posedge clk);
        if (!ifv || fw) m_starve = 0;
        else if (fe && m_starve < 4) m_starve++;
        if (fw) begin
            mf_full = 1; mf_data = ref_mem[if_addr[7:2]];
        end else if (mf_full && if_rr) mf_full = 0;
        if (dw) begin
            md_full = 1; md_err = mis;
            if (mis || dwe) md_data = 32'h0;
            else md_data = ld_ext(ref_mem[d_addr[7:2]], d_size, d_addr[1:0]);
            if (dwe && !mis) ref_mem[d_addr[7:2]] = st_merge(ref_mem[d_addr[7:2]], d_wdata, d_size, d_addr[1:0]);
        end else if (md_full && d_rr) md_full = 0;
        #1;
    endtask

    task automatic set_idle();
        ifv = 0; dv = 0; dwe = 0; if_rr = 1; d_rr = 1;
    endtask

    task automatic dreq(input logic [31:0] a, input logic we, input logic [2:0] sz, input logic [31:0] wd);
        dv = 1; d_addr = a; dwe = we; d_size = sz; d_wdata = wd;
    endtask

    typedef struct {
        logic        ifv; logic [31:0] ia;
        logic        dv;  logic [31:0] da; logic we; logic [2:0] sz; logic [31:0] wd;
        logic        e_ifr, e_dr, e_ren, e_wen; logic [31:0] e_addr; logic e_err;
    } vec_t;

    vec_t vt [10];
    logic [31:0] saved;

    initial begin
        vt[0] = '{1, 32'h0100_0007, 0, 32'h0, 0, 3'd0, 32'h0,         1, 0, 1, 0, 32'h0100_0004, 0};
        vt[1] = '{0, 32'h0, 1, 32'h0100_0008, 0, 3'd2, 32'h0,         0, 1, 1, 0, 32'h0100_0008, 0};
        vt[2] = '{0, 32'h0, 1, 32'h0100_0001, 0, 3'd1, 32'h0,         0, 1, 0, 0, 32'h0100_0001, 1};
        vt[3] = '{0, 32'h0, 1, 32'h0100_0002, 1, 3'd2, 32'h5555_AAAA, 0, 1, 0, 0, 32'h0100_0002, 1};
        vt[4] = '{0, 32'h0, 1, 32'h0100_0003, 0, 3'd0, 32'h0,         0, 1, 1, 0, 32'h0100_0003, 0};
        vt[5] = '{1, 32'h0100_0020, 1, 32'h0100_0006, 1, 3'd1, 32'h0000_BEEF, 0, 1, 0, 1, 32'h0100_0006, 0};
        vt[6] = '{0, 32'h0, 1, 32'h0100_0002, 0, 3'd3, 32'h0,         0, 1, 0, 0, 32'h0100_0002, 1};
        vt[7] = '{0, 32'h0, 1, 32'h0100_0004, 1, 3'd6, 32'hCAFE_F00D, 0, 1, 0, 1, 32'h0100_0004, 0};
        vt[8] = '{0, 32'h0, 1, 32'h0100_0002, 0, 3'd5, 32'h0,         0, 1, 1, 0, 32'h0100_0002, 0};
        vt[9] = '{0, 32'h0, 0, 32'h0, 0, 3'd0, 32'h0,                 0, 0, 0, 0, 32'h0, 0};

        model_clear();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_en = 1; pre_idx = 6'(i); pre_dat = 32'hA500_0000 ^ (32'(i) * 32'h0101_0107);
            ref_mem[i] = pre_dat;
        end
        @(negedge clk) pre_en = 0;

        // Reset and idle
        chk("rst_if_valid", 32'(if_rv), 32'h0);
        chk("rst_d_valid", 32'(d_rv), 32'h0);
        chk("rst_d_err", 32'(d_err), 32'h0);
        @(posedge clk); #1 rst = 0;
        set_idle(); step(); step();

        // Table vectors, each followed by an idle cycle
        foreach (vt[k]) begin
            ifv = vt[k].ifv; if_addr = vt[k].ia;
            dv = vt[k].dv; d_addr = vt[k].da; dwe = vt[k].we; d_size = vt[k].sz; d_wdata = vt[k].wd;
            #1;
            chk($sformatf("vec%0d_if_ready", k), 32'(if_rdy), 32'(vt[k].e_ifr));
            chk($sformatf("vec%0d_d_ready", k), 32'(d_rdy), 32'(vt[k].e_dr));
            chk($sformatf("vec%0d_ren", k), 32'(m_ren), 32'(vt[k].e_ren));
            chk($sformatf("vec%0d_wen", k), 32'(m_wen), 32'(vt[k].e_wen));
            chk($sformatf("vec%0d_addr", k), m_addr, vt[k].e_addr);
            step();
            if (vt[k].e_dr) chk($sformatf("vec%0d_err", k), 32'(d_err), 32'(vt[k].e_err));
            set_idle(); step();
        end

        // Store then load of the same word
        dreq(32'h0100_0010, 1, 3'd2, 32'hDEAD_BEEF); step();
        chk("sw_rsp_data", d_rdata, 32'h0);
        chk("sw_rsp_err", 32'(d_err), 32'h0);
        dreq(32'h0100_0013, 0, 3'd4, 32'h0); step();
        chk("lbu_rsp_data", d_rdata, 32'h0000_00DE);
        set_idle(); step();

        // Contention: D,D,D,D,F repeating
        for (int k = 0; k < 10; k++) begin
            ifv = 1; if_addr = 32'h0100_0040 + 32'(4 * k);
            dreq(32'h0100_0080 + 32'(4 * k), 0, 3'd2, 32'h0);
            #1 chk($sformatf("fair%0d_if_ready", k), 32'(if_rdy), 32'((k % 5) == 4));
            step();
        end
        set_idle(); step();

        // Misaligned load and store
        dreq(32'h0100_0001, 0, 3'd1, 32'h0);
        #1 chk("lh_mis_ren", 32'(m_ren), 32'h0);
        step();
        chk("lh_mis_err", 32'(d_err), 32'h1);
        chk("lh_mis_data", d_rdata, 32'h0);
        saved = ref_mem[0];
        dreq(32'h0100_0002, 1, 3'd2, 32'h1234_5678); step();
        dreq(32'h0100_0000, 0, 3'd2, 32'h0); step();
        chk("sw_mis_unchanged", d_rdata, saved);
        set_idle(); step();

        // Fetch backpressure
        ifv = 1; if_addr = 32'h0100_0044; if_rr = 0; step();
        if_addr = 32'h0100_0048;
        for (int k = 0; k < 3; k++) begin
            dreq(32'h0100_0000 + 32'(4 * k), 0, 3'd2, 32'h0);
            #1 chk("bp_if_ready", 32'(if_rdy), 32'h0);
            chk("bp_d_ready", 32'(d_rdy), 32'h1);
            step();
        end
        dv = 0; if_rr = 1;
        #1 chk("bp_regrant", 32'(if_rdy), 32'h1);
        step();
        chk("bp_new_valid", 32'(if_rv), 32'h1);
        chk("bp_new_data", if_rdata, ref_mem[18]);
        set_idle(); step();

        // Reset with both buffers full
        ifv = 1; if_addr = 32'h0100_004C; if_rr = 0; step();
        ifv = 0; dreq(32'h0100_0008, 0, 3'd2, 32'h0); d_rr = 0; step();
        chk("pend_if_full", 32'(if_rv), 32'h1);
        chk("pend_d_full", 32'(d_rv), 32'h1);
        ifv = 1; rst = 1;
        #1;
        chk("arst_if_valid", 32'(if_rv), 32'h0);
        chk("arst_d_valid", 32'(d_rv), 32'h0);
        chk("arst_ren", 32'(m_ren), 32'h0);
        chk("arst_wen", 32'(m_wen), 32'h0);
        model_clear();
        @(posedge clk); @(posedge clk); #1 rst = 0;
        if_rr = 1; d_rr = 1;
        #1 chk("post_rst_d_first", 32'(d_rdy), 32'h1);
        step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] szs [5];
            szs[0] = 3'd0; szs[1] = 3'd1; szs[2] = 3'd2; szs[3] = 3'd4; szs[4] = 3'd5;
            ifv = ($urandom % 4) != 0;
            if_addr = 32'h0100_0000 | 32'($urandom_range(0, 255));
            if_rr = ($urandom % 4) != 0;
            d_rr = ($urandom % 4) != 0;
            dreq(32'h0100_0000 | 32'($urandom_range(0, 255)), ($urandom % 3) == 0,
                 szs[$urandom_range(0, 4)], $urandom);
            dv = ($urandom % 4) != 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the unified byte-addressable `memory` instance (combinational read, posedge write). It shares that single memory between the instruction-fetch port and the load/store data port. Each cycle it grants at most one access, captures read data into a per-port one-entry response buffer, and returns it over a valid/ready handshake. Data accesses have priority; a starvation counter bounds how long fetch can be locked out. Misaligned data accesses are rejected without touching memory.

## Interface
Parameters:
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width
- `STARVE_LIMIT`, 4, consecutive fetch losses after which fetch wins the next tie (≥1)

Ports:
- `clk` in 1: single clock; all state on posedge
- `rst` in 1: asynchronous, active-high reset
- `if_req_valid_i` in 1: fetch request
- `if_req_ready_o` out 1: fetch request accepted this cycle
- `if_req_addr_i` in AWIDTH: fetch address; bits [1:0] forced to 0 on `mem_addr_o`
- `if_rsp_valid_o` out 1: fetch response buffer full
- `if_rsp_ready_i` in 1: fetch consumer takes response
- `if_rsp_data_o` out DWIDTH: fetched word
- `d_req_valid_i` in 1: data request
- `d_req_ready_o` out 1: data request accepted this cycle
- `d_req_addr_i` in AWIDTH: data address
- `d_req_we_i` in 1: 1 = store, 0 = load
- `d_req_size_i` in 3: funct3 encoding (0 B, 1 H, 2 W, 4 BU, 5 HU)
- `d_req_wdata_i` in DWIDTH: store data
- `d_rsp_valid_o` out 1: data response buffer full (loads and stores)
- `d_rsp_ready_i` in 1: data consumer takes response
- `d_rsp_data_o` out DWIDTH: load data; 0 for stores and errors
- `d_rsp_err_o` out 1: misaligned access, no memory effect
- `mem_addr_o` out AWIDTH, `mem_data_o` out DWIDTH, `mem_size_o` out 3, `mem_read_en_o` out 1, `mem_write_en_o` out 1: connect to the memory's `addr_i`, `data_i`, `size_encoded_i`, `read_en_i`, `write_en_i`
- `mem_data_i` in DWIDTH: memory `data_o`

## Operation
- Port eligible = `req_valid` and (response buffer empty or `rsp_ready` high this cycle). This allows back-to-back issue while draining.
- Selection when both ports are eligible: data wins, unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins. A single eligible port always wins.
- `req_ready_o` = eligible and selected. It is combinational from the other port's valid and from this port's `rsp_ready_i`.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):
  - +1 when fetch is eligible and loses.
  - Cleared when fetch is granted or `if_req_valid_i` is low.
  - Saturates at `STARVE_LIMIT`.
- Fetch grant drives: `mem_addr_o = {addr[AWIDTH-1:2],2'b00}`, `mem_size_o = 3'b010`, `mem_read_en_o = 1`.
- Data grant drives: `mem_addr_o = d_req_addr_i`, `mem_size_o = d_req_size_i`, `mem_data_o = d_req_wdata_i`. Then `mem_read_en_o = !we`, `mem_write_en_o = we`.
- Misaligned data request: H/HU with `addr[0]`, or W with `addr[1:0] != 0`.
  - Still granted, but both enables stay 0.
  - Response has `err = 1`, `data = 0`.
- No grant: all `mem_*` outputs are 0.
- Response capture at the posedge ending the grant cycle:
  - Loads and fetches latch `mem_data_i`.
  - Stores latch data 0, err 0.
  - `rsp_valid_o` is set.
- `rsp_valid_o` clears on `rsp_valid_o && rsp_ready_i` unless a new capture occurs at the same edge; capture takes precedence, so the buffer stays full with the new data.
- Undefined `d_req_size_i` (3, 6, 7) is treated as W for alignment and passed through unchanged.

## Timing
- Reset values: all `*_rsp_valid_o`, `d_rsp_err_o`, response data = 0; `starve_cnt` = 0. `mem_*` outputs = 0 while `rst` is high.
- Reset mid-operation discards buffered responses; a store already committed at an earlier edge is not undone.
- Grant and memory drive occur in cycle N, combinationally.
- Read latency: response visible in cycle N+1. Sustained throughput is one access per cycle total across both ports.
- A store granted in N is written at the end of N; a load granted in N+1 to the same address returns the new data.
- A response held by a low `rsp_ready_i` blocks only that port; the other port keeps issuing.
- Worst-case fetch wait under continuous data traffic: `STARVE_LIMIT` cycles, then one grant.

## Test plan
- **Reset/idle.** Assert `rst` asynchronously mid-cycle → all valids 0 immediately. Deassert with no requests → `mem_read_en_o = mem_write_en_o = 0`.
- **Store then load.** SW 0xDEADBEEF @0x01000010 in cycle 1, LBU @0x01000013 in cycle 2.
  - `d_rsp` in cycle 2: data 0, err 0.
  - `d_rsp` in cycle 3: data 0x000000DE.
- **Contention and fairness.** `STARVE_LIMIT = 4`; both ports valid every cycle, all rsp_ready = 1 → grant pattern D,D,D,D,F repeats. Fetch responses return the words at the requested addresses.
- **Misaligned.** LH @0x01000001 → `mem_read_en_o = 0` that cycle; next cycle `d_rsp_err_o = 1`, data 0. SW @0x01000002 → no write; memory content unchanged.
- **Backpressure.**
  - `if_rsp_ready_i = 0` with fetch response pending → `if_req_ready_o = 0`; data accesses still granted each cycle.
  - Raise `if_rsp_ready_i` with a new fetch valid → same-cycle re-grant; next-cycle `if_rsp_data_o` updates with no bubble.
- **Reset with pending responses.** Both buffers full, assert `rst` → both `rsp_valid` 0; after release the first grant goes to data if both are valid.
